// File: rtl/modb_counter.sv
// Multi-digit counter in an arbitrary radix: up/down, synchronous clear,
// parallel load, combinational carry/borrow out and a sticky wrap flag.
module modb_counter #(
  parameter int BASE    = 10,
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
) (
  input  logic                        clock,
  input  logic                        reset_,
  input  logic                        ei,
  input  logic                        up,
  input  logic                        clr,
  input  logic                        load,
  input  logic [DIGITS*DIGIT_W-1:0]   din,
  output logic [DIGITS*DIGIT_W-1:0]   q,
  output logic                        eu,
  output logic                        wrap
);

  localparam logic [DIGIT_W-1:0] MAX_D  = DIGIT_W'(BASE - 1);
  localparam logic [DIGIT_W:0]   BASE_X = (DIGIT_W + 1)'(BASE);

  function automatic logic [DIGIT_W-1:0] step_digit(input logic [DIGIT_W-1:0] d,
                                                    input logic inc);
    if (inc) return (d == MAX_D) ? '0 : d + 1'b1;
    else     return (d == '0) ? MAX_D : d - 1'b1;
  endfunction

  // Out-of-range load digits collapse to 0 so every digit stays in 0..BASE-1.
  function automatic logic [DIGIT_W-1:0] sanitize(input logic [DIGIT_W-1:0] d);
    return ({1'b0, d} >= BASE_X) ? '0 : d;
  endfunction

  logic [DIGITS*DIGIT_W-1:0] r_q;
  logic [DIGITS*DIGIT_W-1:0] w_q_next;
  logic                      r_wrap;
  logic                      w_wrap_next;
  logic [DIGITS-1:0]         w_run;
  logic                      w_term;

  // w_run[k]: ei is set and every digit below k sits at its terminal value.
  always_comb begin
    logic t;
    t      = 1'b1;
    w_run  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_run[k] = ei & t;
      t = t & (up ? (r_q[k*DIGIT_W +: DIGIT_W] == MAX_D)
                  : (r_q[k*DIGIT_W +: DIGIT_W] == '0));
    end
    w_term = t;
  end

  assign eu = ei & ~clr & ~load & w_term;

  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = r_wrap;
    if (clr) begin
      w_q_next    = '0;
      w_wrap_next = 1'b0;
    end else if (load) begin
      for (int k = 0; k < DIGITS; k++)
        w_q_next[k*DIGIT_W +: DIGIT_W] = sanitize(din[k*DIGIT_W +: DIGIT_W]);
      w_wrap_next = 1'b0;
    end else begin
      for (int k = 0; k < DIGITS; k++)
        if (w_run[k])
          w_q_next[k*DIGIT_W +: DIGIT_W] = step_digit(r_q[k*DIGIT_W +: DIGIT_W], up);
      if (ei && w_term) w_wrap_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;

endmodule
